writeback_stage: RTL

- Final pipeline stage. Sits directly downstream of the memory stage and consumes its registered outputs: scalar destination value, vector destination value, CC value, write-enables and valid.
- Produces write ports back to decode: scalar RF, vector RF and CC register.
- The vector RF write port is one lane wide, so a vector write is serialized over LANES cycles.
- While serializing, the stage asserts a stall back to the memory stage.

---
 rtl/writeback_stage_pkg.sv | 24 ++
 rtl/wb_vec_serializer.sv | 97 +++++++++
 rtl/writeback_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/writeback_stage_pkg.sv
// ============================================================================
// writeback_stage_pkg : shared widths and writeback state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package writeback_stage_pkg;

    localparam int REG_W      = 16;
    localparam int LANES      = 4;
    localparam int LANE_W     = 16;
    localparam int VREG_ID_W  = 6;
    localparam int CNT_W      = 32;
    localparam int VEC_W      = LANES * LANE_W;
    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [0:0] {
        WB_IDLE  = 1'b0,
        WB_DRAIN = 1'b1
    } wb_state_t;

endpackage : writeback_stage_pkg

`default_nettype wire

// File: rtl/wb_vec_serializer.sv
// ============================================================================
// wb_vec_serializer : splits one vector write into LANES single-lane writes
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_vec_serializer
    import writeback_stage_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [VREG_ID_W-1:0]  i_idx,
    input  logic [VEC_W-1:0]      i_vec,
    output logic                  o_wen,
    output logic [VREG_ID_W-1:0]  o_idx,
    output logic [LANE_IDX_W-1:0] o_lane,
    output logic [LANE_W-1:0]     o_data,
    output logic                  o_stall
);

    localparam logic [LANE_IDX_W-1:0] c_last_lane = LANE_IDX_W'(LANES - 1);

    wb_state_t               r_state;
    wb_state_t               w_next_state;
    logic [VEC_W-1:0]        r_vec;
    logic [VREG_ID_W-1:0]    r_idx;
    logic [LANE_IDX_W-1:0]   r_lane;
    logic                    r_wen;
    logic [LANE_IDX_W-1:0]   r_out_lane;
    logic [LANE_W-1:0]       r_out_data;

    logic                    w_emit;
    logic [LANE_IDX_W-1:0]   w_emit_lane;
    logic [LANE_W-1:0]       w_emit_data;

    // Lane 0 goes straight from the input so the first write costs no extra cycle
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_emit_lane  = '0;
        w_emit_data  = '0;
        case (r_state)
            WB_IDLE: begin
                if (i_load) begin
                    w_emit       = 1'b1;
                    w_emit_data  = i_vec[LANE_W-1:0];
                    w_next_state = WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                w_emit      = 1'b1;
                w_emit_lane = r_lane;
                w_emit_data = r_vec[r_lane*LANE_W +: LANE_W];
                if (r_lane == c_last_lane) begin
                    w_next_state = WB_IDLE;
                end
            end
            default: w_next_state = WB_IDLE;
        endcase
    end

    always_ff @(negedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= WB_IDLE;
            r_vec      <= '0;
            r_idx      <= '0;
            r_lane     <= '0;
            r_wen      <= 1'b0;
            r_out_lane <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_next_state;
            r_wen   <= w_emit;
            if (r_state == WB_IDLE && i_load) begin
                r_vec  <= i_vec;
                r_idx  <= i_idx;
                r_lane <= LANE_IDX_W'(1);
            end else if (r_state == WB_DRAIN) begin
                r_lane <= r_lane + 1'b1;
            end
            if (w_emit) begin
                r_out_lane <= w_emit_lane;
                r_out_data <= w_emit_data;
            end
        end
    end

    assign o_wen   = r_wen;
    assign o_idx   = r_idx;
    assign o_lane  = r_out_lane;
    assign o_data  = r_out_data;
    assign o_stall = (r_state == WB_DRAIN);

endmodule : wb_vec_serializer

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// writeback_stage : final pipeline stage driving scalar/vector RF and CC writes
// Optional retire counter built only when WB_RETIRE_CNT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic                    I_CLOCK,
    input  logic                    I_LOCK,
    input  logic                    I_MEM_Valid,
    input  logic [7:0]              I_Opcode,
    input  logic [15:0]             I_PC,
    input  logic [3:0]              I_DestRegIdx,
    input  logic [REG_W-1:0]        I_DestValue,
    input  logic                    I_RegWEn,
    input  logic [VREG_ID_W-1:0]    I_DestVRegIdx,
    input  logic [VEC_W-1:0]        I_VecDestValue,
    input  logic                    I_VRegWEn,
    input  logic [2:0]              I_CCValue,
    input  logic                    I_CCWEn,
    output logic                    O_RegWEn,
    output logic [3:0]              O_WriteBackRegIdx,
    output logic [REG_W-1:0]        O_WriteBackData,
    output logic                    O_VRegWEn,
    output logic [VREG_ID_W-1:0]    O_VRegIdx,
    output logic [LANE_IDX_W-1:0]   O_VRegLane,
    output logic [LANE_W-1:0]       O_VRegLaneData,
    output logic                    O_CCWEn,
    output logic [2:0]              O_CCValue,
    output logic                    O_WBStall,
    output logic [15:0]             O_RetirePC,
    output logic [CNT_W-1:0]        O_RetireCount
);

    logic             w_stall;
    logic             w_accept;
    logic             r_reg_wen;
    logic [3:0]       r_wb_idx;
    logic [REG_W-1:0] r_wb_data;
    logic             r_cc_wen;
    logic [2:0]       r_cc;
    logic [15:0]      r_retire_pc;

    // Opcode is carried for debug visibility only
    logic w_unused_opcode;
    assign w_unused_opcode = &{1'b0, I_Opcode};

    assign w_accept = I_MEM_Valid && !w_stall;

    wb_vec_serializer u_vec_serializer (
        .i_clk   (I_CLOCK),
        .i_rst_n (I_LOCK),
        .i_load  (w_accept && I_VRegWEn),
        .i_idx   (I_DestVRegIdx),
        .i_vec   (I_VecDestValue),
        .o_wen   (O_VRegWEn),
        .o_idx   (O_VRegIdx),
        .o_lane  (O_VRegLane),
        .o_data  (O_VRegLaneData),
        .o_stall (w_stall)
    );

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            r_reg_wen   <= 1'b0;
            r_wb_idx    <= '0;
            r_wb_data   <= '0;
            r_cc_wen    <= 1'b0;
            r_cc        <= '0;
            r_retire_pc <= '0;
        end else begin
            r_reg_wen <= w_accept && I_RegWEn;
            r_cc_wen  <= w_accept && I_CCWEn;
            if (w_accept) begin
                r_wb_idx    <= I_DestRegIdx;
                r_wb_data   <= I_DestValue;
                r_cc        <= I_CCValue;
                r_retire_pc <= I_PC;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            r_retire_cnt <= '0;
        end else if (w_accept) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign O_RetireCount = r_retire_cnt;
`else
    assign O_RetireCount = '0;
`endif

    assign O_RegWEn          = r_reg_wen;
    assign O_WriteBackRegIdx = r_wb_idx;
    assign O_WriteBackData   = r_wb_data;
    assign O_CCWEn           = r_cc_wen;
    assign O_CCValue         = r_cc;
    assign O_WBStall         = w_stall;
    assign O_RetirePC        = r_retire_pc;

endmodule : writeback_stage

`default_nettype wire
